// File: rtl/uart_pkg.sv
// uart_pkg: receiver FSM states, parity encodings and tuser bit positions shared by the UART rx slice
package uart_pkg;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT} rx_state_t;
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD = 1;
    localparam int PAR_EVEN = 2;
    localparam int TU_FRAME = 0;
    localparam int TU_PARITY = 1;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO holding received {tuser,tdata} words; a push while full is accepted only with a same-cycle pop
module uart_rx_fifo #(
    parameter int W = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr, rd;
    logic [AW:0] cnt;
    logic wen, ren;
    assign ren = pop && !empty;
    assign wen = push && (!full || ren);
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign dout = mem[rd];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr <= '0;
            rd <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wen) mem[wr] <= din;
            wr <= wen ? wr + 1'b1 : wr;
            rd <= ren ? rd + 1'b1 : rd;
            cnt <= cnt + (AW+1)'(wen) - (AW+1)'(ren);
        end
    end
endmodule

// File: rtl/uart_rx_axis.sv
// uart_rx_axis: oversampling UART receiver with AXI4-Stream output.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry output FIFO; otherwise a single holding register.
module uart_rx_axis
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic [1:0]           m_axis_tuser,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 overrun,
    output logic                 busy
);
    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int CW = $clog2(DIV);
    localparam int SW = $clog2(OVERSAMPLE);

    if (DIV < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("uart_rx_axis: DIV must be >= 2 and FIFO_DEPTH a power of 2");
    end

    rx_state_t state, nstate;
    logic s1, s2, rx_d, v0, v1, vote, fall, tick, mid, last_data, last_stop;
    logic perr, ferr, push, full, pop;
    logic [CW-1:0] cnt;
    logic [SW-1:0] scnt;
    logic [3:0] bcnt;
    logic [DATA_BITS-1:0] shreg;
    logic [1:0] flags;

    assign fall = state == S_IDLE && rx_d && !s2;
    assign tick = cnt == CW'(DIV - 1);
    assign mid = tick && scnt == SW'(OVERSAMPLE / 2 + 1);
    assign vote = (v0 & v1) | (v0 & s2) | (v1 & s2);
    assign last_data = bcnt == 4'(DATA_BITS - 1);
    assign last_stop = bcnt == 4'(STOP_BITS - 1);
    assign busy = state != S_IDLE;
    assign pop = m_axis_tvalid && m_axis_tready;
    assign flags[TU_PARITY] = perr;
    assign flags[TU_FRAME] = ferr;

    // Synchroniser presets to idle-high so reset release never looks like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {s1, s2, rx_d} <= 3'b111;
            cnt <= '0;
            scnt <= '0;
            v0 <= 1'b1;
            v1 <= 1'b1;
            state <= S_IDLE;
        end else begin
            {s1, s2, rx_d} <= {rx, s1, s2};
            cnt <= (fall || tick) ? '0 : cnt + 1'b1;
            scnt <= fall ? '0 : tick ? scnt + 1'b1 : scnt;
            if (tick && scnt == SW'(OVERSAMPLE / 2 - 1)) v0 <= s2;
            if (tick && scnt == SW'(OVERSAMPLE / 2)) v1 <= s2;
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            S_IDLE:     nstate = fall ? S_START : S_IDLE;
            S_START:    nstate = mid ? (vote ? S_IDLE : S_DATA) : S_START;
            S_DATA:     nstate = (mid && last_data) ? (PARITY != PAR_NONE ? S_PARITY : S_STOP) : S_DATA;
            S_PARITY:   nstate = mid ? S_STOP : S_PARITY;
            S_STOP:     nstate = (mid && last_stop) ? (((ferr || !vote) && shreg == '0) ? S_BRK_WAIT : S_IDLE) : S_STOP;
            S_BRK_WAIT: nstate = s2 ? S_IDLE : S_BRK_WAIT;
            default:    nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            bcnt <= '0;
            perr <= 1'b0;
            ferr <= 1'b0;
            push <= 1'b0;
        end else begin
            push <= mid && state == S_STOP && last_stop;
            if (fall) begin
                shreg <= '0;
                bcnt <= '0;
                perr <= 1'b0;
                ferr <= 1'b0;
            end else if (mid) begin
                if (state == S_DATA) begin
                    shreg <= {vote, shreg[DATA_BITS-1:1]};
                    bcnt <= last_data ? '0 : bcnt + 1'b1;
                end
                if (state == S_PARITY) perr <= (PARITY == PAR_ODD) ? !(^shreg ^ vote) : (^shreg ^ vote);
                if (state == S_STOP) begin
                    ferr <= ferr | !vote;
                    bcnt <= bcnt + 1'b1;
                end
            end
        end
    end

`ifdef UART_RX_FIFO_EN
    logic empty;
    logic [DATA_BITS+1:0] dout;
    uart_rx_fifo #(.W(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .pop(pop),
        .din({flags, shreg}),
        .dout(dout),
        .full(full),
        .empty(empty)
    );
    assign {m_axis_tuser, m_axis_tdata} = dout;
    assign m_axis_tvalid = !empty;
`else
    assign full = m_axis_tvalid;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tdata <= '0;
            m_axis_tuser <= '0;
            m_axis_tvalid <= 1'b0;
        end else if (push && (!full || pop)) begin
            m_axis_tdata <= shreg;
            m_axis_tuser <= flags;
            m_axis_tvalid <= 1'b1;
        end else if (pop) begin
            m_axis_tvalid <= 1'b0;
        end
    end
`endif

    // New word is dropped when the store is full and nothing leaves this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overrun <= 1'b0;
        else overrun <= push && full && !pop;
    end
endmodule

// File: tb/tb_uart_rx_axis.sv
// tb_uart_rx_axis: directed checks of uart_rx_axis in 8N1 and 8E1 builds, 160 clk per bit
module tb_uart_rx_axis;
    localparam int BIT = 160;
    logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, rx_p = 1'b1, tready = 1'b1;
    logic [7:0] tdata, tdata_p;
    logic [1:0] tuser, tuser_p;
    logic tvalid, tvalid_p, ovr, ovr_p, busy, busy_p;
    logic [9:0] q[$], qp[$];
    int n_ovr = 0, n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    uart_rx_axis #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .m_axis_tdata(tdata), .m_axis_tuser(tuser),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready), .overrun(ovr), .busy(busy));

    uart_rx_axis #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16), .DATA_BITS(8),
                   .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_p (
        .clk(clk), .rst_n(rst_n), .rx(rx_p), .m_axis_tdata(tdata_p), .m_axis_tuser(tuser_p),
        .m_axis_tvalid(tvalid_p), .m_axis_tready(1'b1), .overrun(ovr_p), .busy(busy_p));

    always @(negedge clk) begin
        #1;
        if (tvalid && tready) q.push_back({tuser, tdata});
        if (tvalid_p) qp.push_back({tuser_p, tdata_p});
        if (ovr) n_ovr++;
    end

    function automatic logic [9:0] q_at(input int i);
        return (q.size() > i) ? q[i] : 10'h3ff;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit p, input logic v, input int clks);
        if (p) rx_p = v;
        else rx = v;
        repeat (clks) @(negedge clk);
    endtask

    // par < 0: no parity bit; otherwise the parity bit value to send
    task automatic send8(input bit p, input logic [7:0] d, input int par);
        drive(p, 1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(p, d[i], BIT);
        if (par >= 0) drive(p, par[0], BIT);
        drive(p, 1'b1, 2 * BIT);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tdata", 32'(tdata), 0);
        check("rst_tuser", 32'(tuser), 0);
        check("rst_tvalid", 32'(tvalid), 0);
        check("rst_overrun", 32'(ovr), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        repeat (BIT) @(negedge clk);

        send8(0, 8'hA5, -1);
        check("t1_count", q.size(), 1);
        check("t1_word", 32'(q_at(0)), 32'h0A5);
        check("t1_overrun", n_ovr, 0);

        send8(1, 8'h37, 0);
        check("t2_count", qp.size(), 1);
        check("t2_word", 32'(qp.size() > 0 ? qp[0] : 10'h3ff), 32'h237);

        q.delete();
        drive(0, 1'b0, 40);
        drive(0, 1'b1, 20);
        check("t3_busy_start", 32'(busy), 1);
        repeat (70) @(negedge clk);
        check("t3_busy_fall", 32'(busy), 0);
        repeat (2 * BIT) @(negedge clk);
        check("t3_no_word", q.size(), 0);

        tready = 1'b0;
        send8(0, 8'h11, -1);
        send8(0, 8'h22, -1);
        check("t4_tvalid", 32'(tvalid), 1);
        check("t4_tdata_held", 32'(tdata), 32'h11);
`ifdef UART_RX_FIFO_EN
        check("t4_overrun", n_ovr, 0);
`else
        check("t4_overrun", n_ovr, 1);
`endif
        tready = 1'b1;
        repeat (6) @(negedge clk);
        check("t4_first", 32'(q_at(0)), 32'h011);
`ifdef UART_RX_FIFO_EN
        check("t4_count", q.size(), 2);
        check("t4_second", 32'(q_at(1)), 32'h022);
`else
        check("t4_count", q.size(), 1);
`endif
        check("t4_tvalid_drop", 32'(tvalid), 0);

        q.delete();
        n_ovr = 0;
        drive(0, 1'b0, 20 * BIT);
        check("t5_busy_held", 32'(busy), 1);
        check("t5_count", q.size(), 1);
        check("t5_break_word", 32'(q_at(0)), 32'h100);
        drive(0, 1'b1, 10);
        check("t5_busy_release", 32'(busy), 0);
        drive(0, 1'b1, BIT);
        send8(0, 8'h5A, -1);
        check("t5_count_after", q.size(), 2);
        check("t5_clean_word", 32'(q_at(1)), 32'h05A);

        q.delete();
        drive(0, 1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(0, 8'hC3 >> i, BIT);
        drive(0, 1'b0, BIT / 2);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_tdata", 32'(tdata), 0);
        check("t6_tvalid", 32'(tvalid), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_overrun", 32'(ovr), 0);
        rst_n = 1'b1;
        drive(0, 1'b1, 2 * BIT);
        check("t6_no_spurious", q.size(), 0);
        send8(0, 8'h5A, -1);
        check("t6_count", q.size(), 1);
        check("t6_word", 32'(q_at(0)), 32'h05A);
        check("t6_overrun_cnt", n_ovr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
